// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the two-core shared-memory arbiter.
package shared_mem_arbiter_pkg;

  localparam int unsigned TAM_DEF    = 16;
  localparam int unsigned LMEM_DEF   = 8;
  localparam int unsigned NCORES_DEF = 2;

  // One transaction walks IDLE -> MEM -> RESP -> IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/shared_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant; owns the last-grant pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_q;

  // Grant the core not served last on a tie; a lone requester always wins.
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = req[1];
    end
  end

  // Pointer resets to 1 so core 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (advance && gnt_valid) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbitrates two cores onto one shared memory port; three-cycle transactions.
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int unsigned TAM    = TAM_DEF,
  parameter int unsigned Lmem   = LMEM_DEF,
  parameter int unsigned Ncores = NCORES_DEF  // only 2 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [Ncores-1:0] dataLoad,
  input  logic [Ncores-1:0] dataWrite,
  input  logic [TAM-1:0]    dataADDR0,
  input  logic [TAM-1:0]    dataADDR1,
  input  logic [TAM-1:0]    dataIN0,
  input  logic [TAM-1:0]    dataIN1,
  output logic [TAM-1:0]    dataOUT0,
  output logic [TAM-1:0]    dataOUT1,
  output logic [Ncores-1:0] ack,
  output logic [Ncores-1:0] stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [Lmem-1:0]   mem_addr,
  output logic [TAM-1:0]    mem_wdata,
  input  logic [TAM-1:0]    mem_rdata
);

  state_e state_q, state_d;

  logic [Ncores-1:0] sreq;
  logic [Ncores-1:0] elig;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              grant_go;

  logic              gnt_q, gnt_d;
  logic              store_q, store_d;
  logic              mem_en_d, mem_we_d;
  logic [Lmem-1:0]   mem_addr_d;
  logic [TAM-1:0]    mem_wdata_d;
  logic [Ncores-1:0] ack_d;
  logic [TAM-1:0]    dout0_d, dout1_d;
  logic [TAM-1:0]    sel_addr, sel_data;

  logic [Ncores-1:0] in_service;
  logic              conflict;
  logic [15:0]       conflict_cnt;

  // Address bits above the region-select bit play no part in arbitration.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{dataADDR0[TAM-1:Lmem+1], dataADDR1[TAM-1:Lmem+1]};

  assign sreq[0] = (dataLoad[0] | dataWrite[0]) & dataADDR0[Lmem];
  assign sreq[1] = (dataLoad[1] | dataWrite[1]) & dataADDR1[Lmem];

  // A core being acked this cycle must not be re-granted on its held request.
  assign stall    = sreq & ~ack;
  assign elig     = stall;
  assign grant_go = (state_q == IDLE) && gnt_valid;

  assign sel_addr = gnt_idx ? dataADDR1 : dataADDR0;
  assign sel_data = gnt_idx ? dataIN1 : dataIN0;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (elig),
    .advance   (grant_go),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_valid) state_d = MEM;
      MEM:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered memory strobes and responses.
  always_comb begin
    gnt_d       = gnt_q;
    store_d     = store_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    ack_d       = '0;
    dout0_d     = dataOUT0;
    dout1_d     = dataOUT1;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          // Capture the granted core's request; later input changes are ignored.
          gnt_d       = gnt_idx;
          store_d     = dataWrite[gnt_idx];
          mem_en_d    = 1'b1;
          mem_we_d    = dataWrite[gnt_idx];
          mem_addr_d  = sel_addr[Lmem-1:0];
          mem_wdata_d = sel_data;
        end
      end
      MEM: ;
      RESP: begin
        ack_d[gnt_q] = 1'b1;
        if (!store_q) begin
          if (gnt_q) begin
            dout1_d = mem_rdata;
          end else begin
            dout0_d = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= 1'b0;
      store_q   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack       <= '0;
      dataOUT0  <= '0;
      dataOUT1  <= '0;
    end else begin
      gnt_q     <= gnt_d;
      store_q   <= store_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      ack       <= ack_d;
      dataOUT0  <= dout0_d;
      dataOUT1  <= dout1_d;
    end
  end

  // A core is in service from MEM through its ack cycle.
  assign in_service[0] = ((state_q != IDLE) && !gnt_q) || ack[0];
  assign in_service[1] = ((state_q != IDLE) &&  gnt_q) || ack[1];
  assign conflict      = (stall[0] & in_service[1]) | (stall[1] & in_service[0]);

  // Saturating count of cycles where one core waits on the other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule
